// File: rtl/out_buffer_pkg.sv
// ---------------------------------------------------------------------------
// out_buffer_pkg
// Shared definitions for the accelerator output path.
//   - top-level accelerator state encoding (shared with the input loader)
//   - image geometry and the default result-word capacity
//   - packed AXIS beat record carried through the output skid buffer
//   - strobe helper for partially filled words
// ---------------------------------------------------------------------------
package out_buffer_pkg;

  // Top-level accelerator states, same encoding as the input loader
  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] PARAM_LOAD  = 2'd1;
  localparam logic [1:0] IMAGE_LOAD  = 2'd2;
  localparam logic [1:0] START_ACCEL = 2'd3;

  // One output image is IMAGE_ROW x IMAGE_ROW bytes, packed four per word
  localparam int IMAGE_ROW     = 48;
  localparam int OUT_WORDS_DEF = IMAGE_ROW * IMAGE_ROW / 4;

  // One AXIS beat as it travels through the skid buffer
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } axis_word_t;

  // Strobe for a word whose highest filled lane is last_lane
  function automatic logic [3:0] strb_mask(input logic [1:0] last_lane);
    logic [3:0] mask;
    case (last_lane)
      2'd0:    mask = 4'h1;
      2'd1:    mask = 4'h3;
      2'd2:    mask = 4'h7;
      default: mask = 4'hF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/out_buffer_if.sv
// ---------------------------------------------------------------------------
// out_buffer_if
// 32-bit AXI-Stream bundle between the result buffer and the DMA S2MM channel.
//   tvalid/tdata/tstrb/tlast : driven by the master
//   tready                   : driven by the slave
// ---------------------------------------------------------------------------
interface out_buffer_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;

  modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/out_buffer_axis_skid_buf.sv
// ---------------------------------------------------------------------------
// axis_skid_buf
// Two-entry registered output stage for any AXIS master. Outputs come straight
// from flops, so o_valid never depends combinationally on i_ready.
//   clk, rstn : clock, synchronous active-low reset
//   i_valid   : push a beat (caller keeps occupancy within two entries)
//   i_data    : beat payload
//   o_valid   : output beat valid
//   i_ready   : downstream ready
//   o_data    : output beat payload (held while stalled)
//   o_count   : number of beats currently held (0..2)
// ---------------------------------------------------------------------------
module axis_skid_buf #(
  parameter int DATA_W = 37
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  logic              r_out_valid;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] r_skid_data;
  logic              w_load;

  // Output register may take a new beat when empty or when its beat leaves
  assign w_load = !r_out_valid || i_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_data   <= '0;
      r_skid_data  <= '0;
    end else if (w_load) begin
      // The older skid beat always goes out first to preserve order
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= i_valid;
        if (i_valid) r_skid_data <= i_data;
      end else begin
        r_out_valid <= i_valid;
        if (i_valid) r_out_data <= i_data;
      end
    end else if (i_valid) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_data;
    end
  end

  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;
  assign o_count = {1'b0, r_out_valid} + {1'b0, r_skid_valid};

endmodule

// File: rtl/out_buffer.sv
// ---------------------------------------------------------------------------
// out_buffer
// AXIS master returning conv-engine results to the DMA. Bytes arriving during
// START_ACCEL are packed four per word (first byte in [7:0]) into a word BRAM,
// then streamed out with tlast on the final word.
//   clk, rstn : clock, synchronous active-low reset
//   i_state   : top-level accelerator state (START_ACCEL enables collection)
//   res_valid, res_data, res_last : result byte stream, no backpressure
//   m_axis    : AXIS master (tvalid/tready/tdata/tstrb/tlast)
//   o_tx_done : one-cycle pulse after the final handshake
//   o_overflow: sticky, a result byte was dropped
// Build option: define OUT_BUF_RELU_EN to clamp negative bytes to 8'h00.
// ---------------------------------------------------------------------------
module out_buffer
  import out_buffer_pkg::*;
#(
  parameter int OUT_WORDS = OUT_WORDS_DEF,
  parameter int ADDR_W    = 10
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [1:0]   i_state,
  input  logic         res_valid,
  input  logic [7:0]   res_data,
  input  logic         res_last,
  out_buffer_if.master m_axis,
  output logic         o_tx_done,
  output logic         o_overflow
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [ADDR_W:0] L_FULL = (ADDR_W+1)'(OUT_WORDS);

  logic [1:0]      r_state;
  logic [1:0]      r_byte_cnt;
  logic [23:0]     r_pack;
  logic [ADDR_W:0] r_wr_addr;
  logic [ADDR_W:0] r_rd_addr;
  logic [ADDR_W:0] r_num_words;
  logic [3:0]      r_last_strb;
  logic            r_overflow;
  logic            r_rd_pend;
  logic            r_rd_last;
  logic [3:0]      r_rd_strb;
  logic [31:0]     r_rd_data;
  logic [31:0]     r_mem [OUT_WORDS];

  logic [7:0]  w_byte;
  logic [31:0] w_wr_word;
  logic        w_byte_ok;
  logic        w_drop_full;
  logic        w_wr_en;
  logic        w_rd_en;
  logic        w_hs;
  logic [1:0]  w_skid_cnt;
  logic [2:0]  w_occ;
  logic        w_room;
  axis_word_t  w_skid_in;
  axis_word_t  w_skid_out;

`ifdef OUT_BUF_RELU_EN
  assign w_byte = res_data[7] ? 8'h00 : res_data;
`else
  assign w_byte = res_data;
`endif

  // A byte that finds the BRAM full (lane 0 empty at the end) is dropped
  assign w_byte_ok   = (r_state == S_COLLECT) && (i_state == START_ACCEL) && res_valid;
  assign w_drop_full = w_byte_ok && (r_wr_addr == L_FULL) && (r_byte_cnt == 2'd0);
  assign w_wr_en     = w_byte_ok && !w_drop_full && ((r_byte_cnt == 2'd3) || res_last);

  // Lanes above the incoming byte stay zero
  always_comb begin
    w_wr_word = 32'h0;
    case (r_byte_cnt)
      2'd0:    w_wr_word = {24'h0, w_byte};
      2'd1:    w_wr_word = {16'h0, w_byte, r_pack[7:0]};
      2'd2:    w_wr_word = {8'h0, w_byte, r_pack[15:0]};
      default: w_wr_word = {w_byte, r_pack};
    endcase
  end

  // Control FSM and write side
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= 2'd0;
      r_pack      <= 24'h0;
      r_wr_addr   <= '0;
      r_num_words <= '0;
      r_last_strb <= 4'h0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_state == START_ACCEL) begin
            r_state    <= S_COLLECT;
            r_overflow <= 1'b0;
            r_wr_addr  <= '0;
            r_byte_cnt <= 2'd0;
          end
        end
        S_COLLECT: begin
          if (i_state != START_ACCEL) begin
            r_state <= S_IDLE;
          end else if (w_drop_full) begin
            r_overflow <= 1'b1;
            if (res_last) begin
              r_state     <= S_DRAIN;
              r_num_words <= L_FULL;
              r_last_strb <= 4'hF;
            end
          end else if (res_valid) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0:    r_pack[7:0]   <= w_byte;
              2'd1:    r_pack[15:8]  <= w_byte;
              2'd2:    r_pack[23:16] <= w_byte;
              default: r_pack        <= r_pack;
            endcase
            if (w_wr_en) r_wr_addr <= r_wr_addr + 1'b1;
            if (res_last) begin
              r_state     <= S_DRAIN;
              r_num_words <= r_wr_addr + 1'b1;
              r_last_strb <= strb_mask(r_byte_cnt);
            end
          end
        end
        S_DRAIN: begin
          if (res_valid) r_overflow <= 1'b1;
          if (w_hs && m_axis.tlast) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Word BRAM, one write port and one registered read port
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_addr[ADDR_W-1:0]] <= w_wr_word;
    if (w_rd_en) r_rd_data <= r_mem[r_rd_addr[ADDR_W-1:0]];
  end

  // A read still in the BRAM pipeline counts against skid space, so issue
  // only when the skid plus in-flight beat leaves a slot after this cycle
  assign w_hs   = m_axis.tvalid && m_axis.tready;
  assign w_occ  = {1'b0, w_skid_cnt} + {2'b0, r_rd_pend};
  assign w_room = w_hs ? (w_occ <= 3'd2) : (w_occ <= 3'd1);
  assign w_rd_en = (r_state == S_DRAIN) && (r_rd_addr < r_num_words) && w_room;

  // Read address and sideband bits travelling alongside the BRAM data
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_addr <= '0;
      r_rd_pend <= 1'b0;
      r_rd_last <= 1'b0;
      r_rd_strb <= 4'h0;
    end else begin
      r_rd_pend <= w_rd_en;
      if (r_state == S_IDLE) r_rd_addr <= '0;
      else if (w_rd_en)      r_rd_addr <= r_rd_addr + 1'b1;
      if (w_rd_en) begin
        r_rd_last <= ((r_rd_addr + 1'b1) == r_num_words);
        r_rd_strb <= ((r_rd_addr + 1'b1) == r_num_words) ? r_last_strb : 4'hF;
      end
    end
  end

  assign w_skid_in = '{data: r_rd_data, strb: r_rd_strb, last: r_rd_last};

  axis_skid_buf #(.DATA_W($bits(axis_word_t))) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (r_rd_pend),
    .i_data  (w_skid_in),
    .o_valid (m_axis.tvalid),
    .i_ready (m_axis.tready),
    .o_data  (w_skid_out),
    .o_count (w_skid_cnt)
  );

  assign m_axis.tdata = w_skid_out.data;
  assign m_axis.tstrb = w_skid_out.strb;
  assign m_axis.tlast = w_skid_out.last;
  assign o_tx_done    = (r_state == S_DONE);
  assign o_overflow   = r_overflow;

endmodule
